vga_sync_gen: RTL
=================

# vga_sync_gen

Raster timing generator for the VGA painting pipeline. Divides the system clock into a pixel-rate strobe, runs the horizontal and vertical position counters, and produces the `hpos`/`vpos`/`enable` inputs for the brush overlay stage. Also produces line/frame strobes and monitor sync pulses, with the syncs optionally delayed to match the downstream pixel-path latency. Sits directly upstream of the brush and framebuffer read stages.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HPOS_WIDTH`, 10, `hpos` width; must hold H_TOTAL-1
- `VPOS_WIDTH`, 10, `vpos` width; must hold V_TOTAL-1
- `CLK_DIV`, 2, `clk` cycles per pixel, ≥1
- `SYNC_ACTIVE`, 1'b0, asserted level of `hsync`/`vsync`
- `PIPE_DELAY`, 2, pixel ticks of sync delay, ≥0 (used only with `VGA_SYNC_PIPE_EN`)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `pix_en`  out  1  one-`clk` strobe marking a new pixel position; feeds the brush `enable`
- `hpos`  out  HPOS_WIDTH  current column, 0..H_TOTAL-1
- `vpos`  out  VPOS_WIDTH  current line, 0..V_TOTAL-1
- `display_on`  out  1  high when hpos<H_VISIBLE and vpos<V_VISIBLE
- `line_start`  out  1  high while hpos==0
- `frame_start`  out  1  high while hpos==0 and vpos==0
- `hsync`  out  1  horizontal sync, SYNC_ACTIVE polarity
- `vsync`  out  1  vertical sync, SYNC_ACTIVE polarity

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. Internal `tick` = (div==CLK_DIV-1). For CLK_DIV=1, `tick` is constant 1.
- On each `tick` edge: if hpos==H_TOTAL-1, hpos←0 and vpos advances; otherwise hpos←hpos+1. vpos advances from V_TOTAL-1 to 0 and otherwise increments. Arithmetic is unsigned with no overflow past the TOTAL-1 bounds.
- All outputs are registered and update on the same `tick` edge as the counters, so they always describe the new (hpos, vpos). `pix_en` is registered `tick`, so it is high for exactly the first `clk` cycle in which a new position is presented.
- Raw hsync is active for hpos in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751). Raw vsync is active for vpos in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491). Both are driven at SYNC_ACTIVE when active and at ~SYNC_ACTIVE otherwise.
- No states beyond the counters. Behaviour between ticks: all outputs hold, except `pix_en`, which drops.

## Timing
- Reset values, all asynchronous:
  - div=0, pix_en=0
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1
  - display_on=0, line_start=0, frame_start=0
  - hsync=vsync=~SYNC_ACTIVE, and all sync delay stages at the same inactive level
- First `tick` after reset release lands on the CLK_DIV-th rising edge. That edge presents hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, pix_en=1.
- Reset asserted mid-frame: the block returns immediately to the reset values; no partial-line output follows.
- pix_en period is exactly CLK_DIV `clk` cycles; the line period is H_TOTAL·CLK_DIV cycles.

## Configuration
- `VGA_SYNC_PIPE_EN` defined: hsync/vsync pass through a PIPE_DELAY-stage shift register that advances only on `tick`. The syncs lag hpos/vpos by PIPE_DELAY pixels, matching framebuffer read plus the brush rgb register. PIPE_DELAY=0 gives no delay.
- Not defined: PIPE_DELAY is ignored, and hsync/vsync are aligned with hpos/vpos.
- hpos, vpos, display_on and the strobes are never delayed.

## Test plan
- Reset, default parameters: all reset values hold; after release, pix_en first rises after the 2nd edge with hpos=0, vpos=0, frame_start=1, then toggles every 2 clk.
- Line wrap: at hpos=799, vpos=10, next tick gives hpos=0, vpos=11, line_start=1, frame_start=0.
- Frame wrap and blanking: at hpos=799, vpos=524, next tick gives (0,0), frame_start=1. display_on=0 at hpos=640 and at vpos=480.
- Sync windows, macro off: hsync=0 exactly for hpos 656..751, vsync=0 exactly for vpos 490..491, 1 elsewhere. With SYNC_ACTIVE=1, the polarity inverts.
- Macro on, PIPE_DELAY=2: hsync falls on the tick where hpos=658 and rises at hpos=754.
- Reset pulse mid-line at hpos=300: outputs return to reset values within the same cycle; restart matches the first scenario.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate strobe, hpos/vpos counters, blanking, strobes and syncs.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync by PIPE_DELAY pixel ticks.
module vga_sync_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   HPOS_WIDTH  = 10,
    parameter int   VPOS_WIDTH  = 10,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  pix_en,
    output logic [HPOS_WIDTH-1:0] hpos,
    output logic [VPOS_WIDTH-1:0] vpos,
    output logic                  display_on,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  hsync,
    output logic                  vsync
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef VGA_SYNC_PIPE_EN
    localparam int SYNC_DLY = PIPE_DELAY;
`else
    // Delay line compiled out: PIPE_DELAY has no effect.
    localparam int SYNC_DLY = PIPE_DELAY * 0;
`endif

    localparam logic [HPOS_WIDTH-1:0] H_LAST = HPOS_WIDTH'(H_TOTAL - 1);
    localparam logic [VPOS_WIDTH-1:0] V_LAST = VPOS_WIDTH'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0]      D_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      r_div;
    logic [DIV_W-1:0]      w_div_nxt;
    logic                  w_tick;
    logic                  w_hline_end;
    logic [HPOS_WIDTH-1:0] r_hpos;
    logic [HPOS_WIDTH-1:0] w_hpos_nxt;
    logic [VPOS_WIDTH-1:0] r_vpos;
    logic [VPOS_WIDTH-1:0] w_vpos_nxt;
    logic                  w_hs_raw;
    logic                  w_vs_raw;
    logic                  w_hs_dly;
    logic                  w_vs_dly;
    logic                  r_pix_en;
    logic                  r_display_on;
    logic                  r_line_start;
    logic                  r_frame_start;
    logic                  r_hsync;
    logic                  r_vsync;

    // Everything below is decoded from the position the next tick will present,
    // so the registered outputs always describe the new (hpos, vpos).
    always_comb begin
        w_tick      = (r_div == D_LAST);
        w_div_nxt   = w_tick ? '0 : r_div + 1'b1;
        w_hline_end = (r_hpos == H_LAST);
        w_hpos_nxt  = w_hline_end ? '0 : r_hpos + 1'b1;
        w_vpos_nxt  = r_vpos;
        if (w_hline_end) begin
            w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;
        end
        w_hs_raw = ((w_hpos_nxt >= HPOS_WIDTH'(HS_FIRST)) && (w_hpos_nxt <= HPOS_WIDTH'(HS_LAST)))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vs_raw = ((w_vpos_nxt >= VPOS_WIDTH'(VS_FIRST)) && (w_vpos_nxt <= VPOS_WIDTH'(VS_LAST)))
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    generate
        if (SYNC_DLY > 0) begin : g_sync_pipe
            logic [SYNC_DLY-1:0] r_hs_pipe;
            logic [SYNC_DLY-1:0] r_vs_pipe;

            // Shifts once per pixel so the lag is counted in pixels, not clk cycles.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_hs_pipe <= {SYNC_DLY{~SYNC_ACTIVE}};
                    r_vs_pipe <= {SYNC_DLY{~SYNC_ACTIVE}};
                end else if (w_tick) begin
                    r_hs_pipe[0] <= w_hs_raw;
                    r_vs_pipe[0] <= w_vs_raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign w_hs_dly = r_hs_pipe[SYNC_DLY-1];
            assign w_vs_dly = r_vs_pipe[SYNC_DLY-1];
        end else begin : g_no_pipe
            assign w_hs_dly = w_hs_raw;
            assign w_vs_dly = w_vs_raw;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
        end else begin
            r_div    <= w_div_nxt;
            r_pix_en <= w_tick;
            if (w_tick) begin
                r_hpos        <= w_hpos_nxt;
                r_vpos        <= w_vpos_nxt;
                r_display_on  <= (w_hpos_nxt < HPOS_WIDTH'(H_VISIBLE)) &&
                                 (w_vpos_nxt < VPOS_WIDTH'(V_VISIBLE));
                r_line_start  <= (w_hpos_nxt == '0);
                r_frame_start <= (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
                r_hsync       <= w_hs_dly;
                r_vsync       <= w_vs_dly;
            end
        end
    end

    assign pix_en      = r_pix_en;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule
